// File: rtl/uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_pkg
// Purpose  : Shared state encodings, parity selectors and line levels for the
//            UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic PAR_EVEN   = 1'b0;
    localparam logic PAR_ODD    = 1'b1;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_serializer
// Purpose  : Payload shift register and bit counter for the UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift_en,
    input  logic                  cnt_en,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;

    // Bit 0 is always the next bit the line will carry.
    assign ser_bit  = r_shift[0];
    assign ser_done = cnt_en && (r_cnt == c_LAST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (load) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else begin
            if (shift_en) begin
                r_shift <= r_shift >> 1;
            end
            if (cnt_en) begin
                r_cnt <= ser_done ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : UART transmit FSM: start bit, LSB-first data, optional parity,
//            one stop bit; one bit per CLK. Parity hardware is built only when
//            UART_TX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t r_state;
    logic      w_accept;
    logic      w_ser_bit;
    logic      w_ser_done;

    assign w_accept = DATA_VALID && ((r_state == ST_IDLE) || (r_state == ST_STOP));

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (w_accept),
        .load_data (P_DATA),
        .shift_en  ((r_state == ST_START) || (r_state == ST_DATA)),
        .cnt_en    (r_state == ST_DATA),
        .ser_bit   (w_ser_bit),
        .ser_done  (w_ser_done)
    );

`ifdef UART_TX_PARITY_EN
    logic r_par_en;
    logic r_par_bit;

    // Parity is resolved at acceptance so the shifting payload is not needed later.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
        end else if (w_accept) begin
            r_par_en  <= PAR_EN;
            r_par_bit <= (^P_DATA) ^ (PAR_TYP == PAR_ODD);
        end
    end
`else
    logic w_unused_par;
    assign w_unused_par = ^{PAR_EN, PAR_TYP};
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= ST_IDLE;
            TX_OUT  <= LINE_IDLE;
            Busy    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_STOP: begin
                    if (w_accept) begin
                        r_state <= ST_START;
                        TX_OUT  <= LINE_START;
                        Busy    <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        TX_OUT  <= LINE_IDLE;
                        Busy    <= 1'b0;
                    end
                end
                ST_START: begin
                    r_state <= ST_DATA;
                    TX_OUT  <= w_ser_bit;
                end
                ST_DATA: begin
                    if (w_ser_done) begin
`ifdef UART_TX_PARITY_EN
                        if (r_par_en) begin
                            r_state <= ST_PARITY;
                            TX_OUT  <= r_par_bit;
                        end else begin
                            r_state <= ST_STOP;
                            TX_OUT  <= LINE_IDLE;
                        end
`else
                        r_state <= ST_STOP;
                        TX_OUT  <= LINE_IDLE;
`endif
                    end else begin
                        TX_OUT <= w_ser_bit;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_STOP;
                    TX_OUT  <= LINE_IDLE;
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    TX_OUT  <= LINE_IDLE;
                    Busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx against a per-bit frame queue
//            model; follows UART_TX_PARITY_EN for the parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int W = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILT = 1'b1;
`else
    localparam bit PAR_BUILT = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] P_DATA = '0;
    logic         DATA_VALID = 1'b0;
    logic         PAR_EN = 1'b0;
    logic         PAR_TYP = 1'b0;
    logic         TX_OUT;
    logic         Busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Line levels still owed by the frame(s) in flight, head = level on the line now.
    bit exp_q[$];

    uart_tx #(.DATA_WIDTH(W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic push_frame(input logic [W-1:0] d, input logic pe, input logic pt);
        exp_q.push_back(1'b0);
        for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
        if (PAR_BUILT && pe) exp_q.push_back(bit'(($countones(d) % 2) != 0) ^ pt);
        exp_q.push_back(1'b1);
    endtask

    task automatic tick(input logic rst, input logic dv, input logic [W-1:0] d,
                        input logic pe, input logic pt);
        bit   idle_or_stop;
        logic exp_tx;
        logic exp_busy;
        RST = rst; DATA_VALID = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
        if (!rst) begin
            exp_q.delete();
        end else begin
            idle_or_stop = (exp_q.size() <= 1);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (dv && idle_or_stop) push_frame(d, pe, pt);
        end
        @(posedge CLK);
        #1;
        cyc++;
        exp_tx   = (exp_q.size() > 0) ? exp_q[0] : 1'b1;
        exp_busy = (exp_q.size() > 0);
        total++;
        assert (TX_OUT === exp_tx) else begin
            bad++;
            $error("FAIL tx_out cyc=%0d observed=%b expected=%b", cyc, TX_OUT, exp_tx);
        end
        total++;
        assert (Busy === exp_busy) else begin
            bad++;
            $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, Busy, exp_busy);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, W'($urandom), 1'($urandom), 1'($urandom));
    endtask

    initial begin
        // reset state
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
        idle(2);

        // even parity 0xA5, one-cycle strobe
        tick(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
        idle(13);

        // odd parity 0x03, then same payload without parity
        tick(1'b1, 1'b1, 8'h03, 1'b1, 1'b1);
        idle(13);
        tick(1'b1, 1'b1, 8'h03, 1'b0, 1'b1);
        idle(12);

        // back-to-back: DATA_VALID held, payload switches to 0xFF after acceptance
        tick(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        idle(14);

        // request during DATA bit 3 is dropped
        tick(1'b1, 1'b1, 8'h80, 1'b1, 1'b1);
        idle(4);
        tick(1'b1, 1'b1, 8'h12, 1'b0, 1'b0);
        idle(12);

        // reset during DATA bit 4, then a clean frame
        tick(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0);
        idle(5);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(2);
        tick(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
        idle(13);

        // random traffic with mid-frame input churn and rare resets
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 149) != 0), 1'($urandom_range(0, 3) == 0),
                 W'($urandom), 1'($urandom), 1'($urandom));
        end
        idle(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
